ras_ctrl: RTL and testbench

//   Return-address-stack controller between fetch predecode and the RAS. Turns
//   per-slot call/ret flags of a 2-slot fetch packet into serialized push/pop

---
 rtl/ras_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ras_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ras_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ras_ctrl
// Purpose  : Return-address-stack controller between fetch predecode and the
//            RAS. Serialises the call/ret flags of a 2-slot fetch packet into
//            push/pop commands (never both in one cycle), forwards the popped
//            return target to next-PC select, and tracks speculative and
//            committed stack depth. After a backend flush it pops surplus
//            wrong-path pushes before accepting new packets.
// Ports    : clk, reset (async, active high)
//            in_valid/in_ready/in_pc/in_slot_valid/in_call/in_ret : packet in
//            ras_push/ras_pop/ras_ret_pc_push/ras_ret_pc_pop      : RAS side
//            pred_valid/pred_slot/pred_target                     : prediction
//            commit_call/commit_ret                               : retirement
//            flush                                                : redirect
// Revision : 1.0 - initial release
// ============================================================================
module ras_ctrl #(
    parameter int RAS_SIZE   = 16,
    parameter int RET_OFFSET = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [1:0]  in_slot_valid,
    input  logic [1:0]  in_call,
    input  logic [1:0]  in_ret,
    output logic        ras_push,
    output logic        ras_pop,
    output logic [31:0] ras_ret_pc_push,
    input  logic [31:0] ras_ret_pc_pop,
    output logic        pred_valid,
    output logic        pred_slot,
    output logic [31:0] pred_target,
    input  logic        commit_call,
    input  logic        commit_ret,
    input  logic        flush
);

    localparam int              c_DW     = $clog2(RAS_SIZE + 1);
    localparam logic [c_DW-1:0] c_MAX    = c_DW'(RAS_SIZE);
    localparam logic [31:0]     c_OFFSET = 32'(RET_OFFSET);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SLOT1  = 2'd1,
        ST_REPAIR = 2'd2
    } state_t;

    state_t          r_state;
    logic [c_DW-1:0] r_spec_depth;
    logic [c_DW-1:0] r_commit_depth;
    logic [31:0]     r_s1_pc;       // slot1 PC held across the SLOT1 cycle
    logic            r_s1_call;     // slot1 is a call (else a ret)

    logic [1:0]      w_ev;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic [31:0]     w_push_pc;
    logic            w_pred;
    logic            w_pred_slot;
    logic            w_repair_more;
    logic [c_DW-1:0] w_commit_next;
    logic [c_DW-1:0] w_spec_next;

    assign w_ev          = in_slot_valid & (in_call | in_ret);
    assign in_ready      = (r_state == ST_IDLE) & ~flush & ~reset;
    assign w_accept      = in_valid & in_ready;
    assign w_repair_more = (r_spec_depth > r_commit_depth);

    // Command decode. Flush suppresses everything, including pending SLOT1 work.
    always_comb begin
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_push_pc   = 32'd0;
        w_pred      = 1'b0;
        w_pred_slot = 1'b0;
        if (!flush) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_ev[0]) begin
                            if (in_call[0]) begin
                                w_push    = 1'b1;
                                w_push_pc = in_pc + c_OFFSET;
                            end else begin
                                w_pop  = 1'b1;
                                w_pred = 1'b1;
                            end
                        end else if (w_ev[1]) begin
                            w_pred_slot = 1'b1;
                            if (in_call[1]) begin
                                w_push    = 1'b1;
                                w_push_pc = in_pc + 32'd4 + c_OFFSET;
                            end else begin
                                w_pop  = 1'b1;
                                w_pred = 1'b1;
                            end
                        end
                    end
                end
                ST_SLOT1: begin
                    w_pred_slot = 1'b1;
                    if (r_s1_call) begin
                        w_push    = 1'b1;
                        w_push_pc = r_s1_pc + c_OFFSET;
                    end else begin
                        w_pop  = 1'b1;
                        w_pred = 1'b1;
                    end
                end
                ST_REPAIR: begin
                    w_pop = w_repair_more;
                end
                default: ;
            endcase
        end
    end

    // Outputs are combinational, so reset gates them directly to stop any
    // command the instant reset rises.
    assign ras_push        = w_push & ~reset;
    assign ras_pop         = w_pop & ~reset;
    assign ras_ret_pc_push = reset ? 32'd0 : w_push_pc;
    assign pred_valid      = w_pred & ~reset;
    assign pred_slot       = w_pred_slot & w_pred & ~reset;
    assign pred_target     = (w_pred & ~reset) ? ras_ret_pc_pop : 32'd0;

    // Committed depth; simultaneous call and ret retirement cancel out.
    always_comb begin
        w_commit_next = r_commit_depth;
        if (commit_call && !commit_ret) begin
            if (r_commit_depth < c_MAX) w_commit_next = r_commit_depth + 1'b1;
        end else if (commit_ret && !commit_call) begin
            if (r_commit_depth != '0) w_commit_next = r_commit_depth - 1'b1;
        end
    end

    // Speculative depth. When resyncing, take the post-commit value so both
    // counters agree even if a retirement lands in the same cycle.
    always_comb begin
        w_spec_next = r_spec_depth;
        if (flush) begin
            if (r_spec_depth <= w_commit_next) w_spec_next = w_commit_next;
        end else if (r_state == ST_REPAIR && !w_repair_more) begin
            w_spec_next = w_commit_next;
        end else if (w_push) begin
            if (r_spec_depth < c_MAX) w_spec_next = r_spec_depth + 1'b1;
        end else if (w_pop) begin
            if (r_spec_depth != '0) w_spec_next = r_spec_depth - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_spec_depth   <= '0;
            r_commit_depth <= '0;
            r_s1_pc        <= 32'd0;
            r_s1_call      <= 1'b0;
        end else begin
            r_spec_depth   <= w_spec_next;
            r_commit_depth <= w_commit_next;
            if (flush) begin
                r_state <= (r_spec_depth > w_commit_next) ? ST_REPAIR : ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept && w_ev[0] && w_ev[1]) begin
                            r_state   <= ST_SLOT1;
                            r_s1_pc   <= in_pc + 32'd4;
                            r_s1_call <= in_call[1];
                        end
                    end
                    ST_SLOT1:  r_state <= ST_IDLE;
                    ST_REPAIR: if (!w_repair_more) r_state <= ST_IDLE;
                    default:   r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ras_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ras_ctrl
// Purpose  : Directed self-checking bench for ras_ctrl. Inputs change on the
//            falling clock edge and outputs are sampled 1 ns later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ras_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [1:0]  in_slot_valid;
    logic [1:0]  in_call;
    logic [1:0]  in_ret;
    logic        ras_push;
    logic        ras_pop;
    logic [31:0] ras_ret_pc_push;
    logic [31:0] ras_ret_pc_pop;
    logic        pred_valid;
    logic        pred_slot;
    logic [31:0] pred_target;
    logic        commit_call;
    logic        commit_ret;
    logic        flush;

    int n_pass;
    int n_total;

    ras_ctrl #(.RAS_SIZE(16), .RET_OFFSET(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pc           (in_pc),
        .in_slot_valid   (in_slot_valid),
        .in_call         (in_call),
        .in_ret          (in_ret),
        .ras_push        (ras_push),
        .ras_pop         (ras_pop),
        .ras_ret_pc_push (ras_ret_pc_push),
        .ras_ret_pc_pop  (ras_ret_pc_pop),
        .pred_valid      (pred_valid),
        .pred_slot       (pred_slot),
        .pred_target     (pred_target),
        .commit_call     (commit_call),
        .commit_ret      (commit_ret),
        .flush           (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        in_valid      = 1'b0;
        in_pc         = 32'd0;
        in_slot_valid = 2'b00;
        in_call       = 2'b00;
        in_ret        = 2'b00;
        commit_call   = 1'b0;
        commit_ret    = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic drive_pkt(input logic [31:0] pc, input logic [1:0] sv,
                             input logic [1:0] c, input logic [1:0] r);
        in_valid      = 1'b1;
        in_pc         = pc;
        in_slot_valid = sv;
        in_call       = c;
        in_ret        = r;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        ras_ret_pc_pop = 32'h0;
        @(negedge clk); #1;
        n_total++; if (ras_push !== 1'b0 || ras_pop !== 1'b0 || pred_valid !== 1'b0) $display("FAIL reset_cmds: got push=%b pop=%b pred=%b want 0 0 0", ras_push, ras_pop, pred_valid); else n_pass++;
        n_total++; if (ras_ret_pc_push !== 32'd0 || pred_target !== 32'd0 || pred_slot !== 1'b0) $display("FAIL reset_data: got pcpush=%h tgt=%h slot=%b want 0", ras_ret_pc_push, pred_target, pred_slot); else n_pass++;
        n_total++; if (dut.r_spec_depth !== 5'd0 || dut.r_commit_depth !== 5'd0) $display("FAIL reset_depth: got spec=%0d commit=%0d want 0 0", dut.r_spec_depth, dut.r_commit_depth); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_call_slot0();
        @(negedge clk);
        drive_pkt(32'h1000, 2'b01, 2'b01, 2'b00);
        #1;
        n_total++; if (ras_push !== 1'b1 || ras_pop !== 1'b0) $display("FAIL call0_cmd: got push=%b pop=%b want 1 0", ras_push, ras_pop); else n_pass++;
        n_total++; if (ras_ret_pc_push !== 32'h1008) $display("FAIL call0_pc: got %h want 00001008", ras_ret_pc_push); else n_pass++;
        n_total++; if (in_ready !== 1'b1 || pred_valid !== 1'b0) $display("FAIL call0_ready: got rdy=%b pred=%b want 1 0", in_ready, pred_valid); else n_pass++;
        @(negedge clk);
        drive_idle();
        #1;
        n_total++; if (dut.r_spec_depth !== 5'd1) $display("FAIL call0_depth: got %0d want 1", dut.r_spec_depth); else n_pass++;
    endtask

    task automatic test_ret_slot1();
        @(negedge clk);
        drive_pkt(32'h3000, 2'b11, 2'b00, 2'b10);
        ras_ret_pc_pop = 32'h2468;
        #1;
        n_total++; if (pred_valid !== 1'b1 || pred_slot !== 1'b1) $display("FAIL ret1_pred: got valid=%b slot=%b want 1 1", pred_valid, pred_slot); else n_pass++;
        n_total++; if (pred_target !== 32'h2468) $display("FAIL ret1_target: got %h want 00002468", pred_target); else n_pass++;
        n_total++; if (ras_pop !== 1'b1 || ras_push !== 1'b0) $display("FAIL ret1_cmd: got pop=%b push=%b want 1 0", ras_pop, ras_push); else n_pass++;
        @(negedge clk);
        drive_idle();
        #1;
        n_total++; if (dut.r_spec_depth !== 5'd0 || in_ready !== 1'b1) $display("FAIL ret1_after: got depth=%0d rdy=%b want 0 1", dut.r_spec_depth, in_ready); else n_pass++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive_pkt(32'h4000, 2'b11, 2'b01, 2'b10);
        ras_ret_pc_pop = 32'h5550;
        #1;
        n_total++; if (ras_push !== 1'b1 || ras_pop !== 1'b0 || ras_ret_pc_push !== 32'h4008) $display("FAIL b2b_c0: got push=%b pop=%b pc=%h want 1 0 00004008", ras_push, ras_pop, ras_ret_pc_push); else n_pass++;
        @(negedge clk);
        drive_idle();
        #1;
        n_total++; if (ras_pop !== 1'b1 || ras_push !== 1'b0 || in_ready !== 1'b0) $display("FAIL b2b_c1: got pop=%b push=%b rdy=%b want 1 0 0", ras_pop, ras_push, in_ready); else n_pass++;
        n_total++; if (pred_valid !== 1'b1 || pred_slot !== 1'b1 || pred_target !== 32'h5550) $display("FAIL b2b_pred: got v=%b s=%b t=%h want 1 1 00005550", pred_valid, pred_slot, pred_target); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (in_ready !== 1'b1 || ras_pop !== 1'b0 || dut.r_spec_depth !== 5'd0) $display("FAIL b2b_end: got rdy=%b pop=%b depth=%0d want 1 0 0", in_ready, ras_pop, dut.r_spec_depth); else n_pass++;
    endtask

    // Both slots call; slot0 also carries a ret flag, which the call overrides.
    task automatic test_call_both();
        @(negedge clk);
        drive_pkt(32'h6000, 2'b11, 2'b11, 2'b01);
        #1;
        n_total++; if (ras_push !== 1'b1 || ras_pop !== 1'b0 || ras_ret_pc_push !== 32'h6008) $display("FAIL both_c0: got push=%b pop=%b pc=%h want 1 0 00006008", ras_push, ras_pop, ras_ret_pc_push); else n_pass++;
        @(negedge clk);
        drive_idle();
        #1;
        n_total++; if (ras_push !== 1'b1 || ras_ret_pc_push !== 32'h600C || in_ready !== 1'b0) $display("FAIL both_c1: got push=%b pc=%h rdy=%b want 1 0000600c 0", ras_push, ras_ret_pc_push, in_ready); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (dut.r_spec_depth !== 5'd2 || in_ready !== 1'b1) $display("FAIL both_depth: got depth=%0d rdy=%b want 2 1", dut.r_spec_depth, in_ready); else n_pass++;
    endtask

    task automatic test_flush_repair();
        int  pops;
        logic gap;
        logic bad;
        logic done;
        pops = 0; gap = 1'b0; bad = 1'b0; done = 1'b0;
        // Third call; slot1 flag ignored because slot1 is not valid.
        @(negedge clk);
        drive_pkt(32'h7000, 2'b01, 2'b11, 2'b00);
        commit_call = 1'b1;
        #1;
        n_total++; if (ras_push !== 1'b1 || ras_ret_pc_push !== 32'h7008) $display("FAIL fl_call: got push=%b pc=%h want 1 00007008", ras_push, ras_ret_pc_push); else n_pass++;
        @(negedge clk);
        drive_idle();
        #1;
        n_total++; if (in_ready !== 1'b1 || dut.r_spec_depth !== 5'd3 || dut.r_commit_depth !== 5'd1) $display("FAIL fl_pre: got rdy=%b spec=%0d commit=%0d want 1 3 1", in_ready, dut.r_spec_depth, dut.r_commit_depth); else n_pass++;
        flush = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b0 || ras_push !== 1'b0 || ras_pop !== 1'b0) $display("FAIL fl_cycle: got rdy=%b push=%b pop=%b want 0 0 0", in_ready, ras_push, ras_pop); else n_pass++;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            #1;
            if (in_ready) done = 1'b1;
            else begin
                if (ras_pop) begin
                    pops++;
                    if (gap) bad = 1'b1;
                end else gap = 1'b1;
                if (ras_push || pred_valid) bad = 1'b1;
                @(negedge clk);
            end
        end
        n_total++; if (!done) $display("FAIL fl_timeout: got ready=0 after 10 cycles want 1"); else n_pass++;
        n_total++; if (pops != 2 || bad) $display("FAIL fl_pops: got %0d pops bad=%b want 2 0", pops, bad); else n_pass++;
        n_total++; if (dut.r_spec_depth !== 5'd1 || dut.r_commit_depth !== 5'd1) $display("FAIL fl_depth: got spec=%0d commit=%0d want 1 1", dut.r_spec_depth, dut.r_commit_depth); else n_pass++;
    endtask

    task automatic test_flush_slot1();
        @(negedge clk);
        drive_pkt(32'h8000, 2'b11, 2'b11, 2'b00);
        @(negedge clk);
        drive_idle();
        flush = 1'b1;
        #1;
        n_total++; if (ras_push !== 1'b0 || ras_pop !== 1'b0 || in_ready !== 1'b0) $display("FAIL fs1_drop: got push=%b pop=%b rdy=%b want 0 0 0", ras_push, ras_pop, in_ready); else n_pass++;
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_total++; if (ras_pop !== 1'b1) $display("FAIL fs1_repair: got pop=%b want 1", ras_pop); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (ras_pop !== 1'b0 || in_ready !== 1'b0) $display("FAIL fs1_last: got pop=%b rdy=%b want 0 0", ras_pop, in_ready); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (in_ready !== 1'b1 || dut.r_spec_depth !== 5'd1) $display("FAIL fs1_end: got rdy=%b depth=%0d want 1 1", in_ready, dut.r_spec_depth); else n_pass++;
    endtask

    task automatic test_saturation();
        int pushes;
        pushes = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive_pkt(32'h9000, 2'b01, 2'b01, 2'b00);
            #1;
            if (ras_push) pushes++;
            @(negedge clk);
        end
        drive_idle();
        #1;
        n_total++; if (pushes != 17) $display("FAIL sat_pushes: got %0d want 17", pushes); else n_pass++;
        n_total++; if (dut.r_spec_depth !== 5'd16) $display("FAIL sat_depth: got %0d want 16", dut.r_spec_depth); else n_pass++;
        commit_call = 1'b1;
        @(negedge clk);
        commit_ret = 1'b1;
        @(negedge clk);
        commit_call = 1'b0; commit_ret = 1'b0;
        #1;
        n_total++; if (dut.r_commit_depth !== 5'd1) $display("FAIL sat_commit_both: got %0d want 1", dut.r_commit_depth); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            drive_pkt(32'hA000, 2'b01, 2'b00, 2'b01);
            @(negedge clk);
        end
        #1;
        n_total++; if (dut.r_spec_depth !== 5'd0) $display("FAIL sat_drain: got %0d want 0", dut.r_spec_depth); else n_pass++;
        ras_ret_pc_pop = 32'h1357;
        #1;
        n_total++; if (ras_pop !== 1'b1 || pred_valid !== 1'b1 || pred_slot !== 1'b0 || pred_target !== 32'h1357) $display("FAIL sat_pop0: got pop=%b v=%b s=%b t=%h want 1 1 0 00001357", ras_pop, pred_valid, pred_slot, pred_target); else n_pass++;
        @(negedge clk);
        drive_idle();
        #1;
        n_total++; if (dut.r_spec_depth !== 5'd0) $display("FAIL sat_floor: got %0d want 0", dut.r_spec_depth); else n_pass++;
    endtask

    task automatic test_reset_in_repair();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_pkt(32'hB000, 2'b01, 2'b01, 2'b00);
        end
        @(negedge clk);
        drive_idle();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_total++; if (ras_pop !== 1'b1) $display("FAIL rr_repair: got pop=%b want 1", ras_pop); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++; if (ras_pop !== 1'b0 || in_ready !== 1'b0) $display("FAIL rr_async: got pop=%b rdy=%b want 0 0", ras_pop, in_ready); else n_pass++;
        n_total++; if (dut.r_state !== 2'd0 || dut.r_spec_depth !== 5'd0 || dut.r_commit_depth !== 5'd0) $display("FAIL rr_state: got st=%0d spec=%0d commit=%0d want 0 0 0", dut.r_state, dut.r_spec_depth, dut.r_commit_depth); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_total++; if (in_ready !== 1'b1 || ras_pop !== 1'b0) $display("FAIL rr_release: got rdy=%b pop=%b want 1 0", in_ready, ras_pop); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_call_slot0();
        test_ret_slot1();
        test_back_to_back();
        test_call_both();
        test_flush_repair();
        test_flush_slot1();
        test_saturation();
        test_reset_in_repair();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
